// File: rtl/distribute_1x2_cmd_flow_pkg.sv
// distribute_1x2_cmd_flow_pkg: shared NoC distribution-tree constants and command-width derivation
package distribute_1x2_cmd_flow_pkg;

    localparam int DESTINATION_TAG_WIDTH = 1;

    function automatic int out_cmd_width(input int in_w, input int tag_w);
        return (in_w > tag_w) ? 2 * (in_w - tag_w) : tag_w;
    endfunction

endpackage

// File: rtl/distribute_1x2_route_comb.sv
// distribute_1x2_route_comb: tag decode and data/command steering for one 1x2 tree node
module distribute_1x2_route_comb
    import distribute_1x2_cmd_flow_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int IN_COMMAND_WIDTH  = 2,
    parameter int OUT_COMMAND_WIDTH = out_cmd_width(2, 1)
) (
    input  logic                         i_valid,
    input  logic                         i_en,
    input  logic [DATA_WIDTH-1:0]        i_data_bus,
    input  logic [IN_COMMAND_WIDTH-1:0]  i_cmd,
    output logic [1:0]                   o_valid,
    output logic [2*DATA_WIDTH-1:0]      o_data_bus,
    output logic [OUT_COMMAND_WIDTH-1:0] o_cmd
);

    logic fire;
    logic to_hi;

    assign fire  = i_en & i_valid;
    assign to_hi = i_cmd[IN_COMMAND_WIDTH-1];

    // one-hot branch select; the unselected branch carries zeros
    always_comb begin
        o_valid    = {fire & to_hi, fire & ~to_hi};
        o_data_bus = {o_valid[1] ? i_data_bus : {DATA_WIDTH{1'b0}},
                      o_valid[0] ? i_data_bus : {DATA_WIDTH{1'b0}}};
    end

    if (IN_COMMAND_WIDTH > 1) begin : g_mid
        localparam int RW = IN_COMMAND_WIDTH - 1;
        logic [RW-1:0] rest;
        assign rest  = i_cmd[RW-1:0];
        assign o_cmd = {o_valid[1] ? rest : {RW{1'b0}},
                        o_valid[0] ? rest : {RW{1'b0}}};
    end else begin : g_last
        assign o_cmd = '0;
    end

endmodule

// File: rtl/distribute_1x2_cmd_flow.sv
// distribute_1x2_cmd_flow: registered 1-to-2 self-routing distribution node
module distribute_1x2_cmd_flow
    import distribute_1x2_cmd_flow_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int DESTINATION_TAG_WIDTH = distribute_1x2_cmd_flow_pkg::DESTINATION_TAG_WIDTH,
    parameter int IN_COMMAND_WIDTH      = 2,
    localparam int OUT_COMMAND_WIDTH    = out_cmd_width(IN_COMMAND_WIDTH, DESTINATION_TAG_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    input  logic [DATA_WIDTH-1:0]        i_data_bus,
    input  logic                         i_en,
    input  logic [IN_COMMAND_WIDTH-1:0]  i_cmd,
    output logic [1:0]                   o_valid,
    output logic [2*DATA_WIDTH-1:0]      o_data_bus,
    output logic [OUT_COMMAND_WIDTH-1:0] o_cmd
);

    if (DESTINATION_TAG_WIDTH != 1) begin : g_bad_tag
        $error("distribute_1x2_cmd_flow: only DESTINATION_TAG_WIDTH=1 is supported");
    end
    if (IN_COMMAND_WIDTH < DESTINATION_TAG_WIDTH) begin : g_bad_cmd
        $error("distribute_1x2_cmd_flow: IN_COMMAND_WIDTH must be >= DESTINATION_TAG_WIDTH");
    end

    logic [1:0]                   o_valid_d,    o_valid_q;
    logic [2*DATA_WIDTH-1:0]      o_data_bus_d, o_data_bus_q;
    logic [OUT_COMMAND_WIDTH-1:0] o_cmd_d,      o_cmd_q;

    distribute_1x2_route_comb #(
        .DATA_WIDTH       (DATA_WIDTH),
        .IN_COMMAND_WIDTH (IN_COMMAND_WIDTH),
        .OUT_COMMAND_WIDTH(OUT_COMMAND_WIDTH)
    ) u_route (
        .i_valid   (i_valid),
        .i_en      (i_en),
        .i_data_bus(i_data_bus),
        .i_cmd     (i_cmd),
        .o_valid   (o_valid_d),
        .o_data_bus(o_data_bus_d),
        .o_cmd     (o_cmd_d)
    );

    // output stage: every cycle takes the freshly steered flit or zeros, nothing is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid_q    <= '0;
            o_data_bus_q <= '0;
            o_cmd_q      <= '0;
        end else begin
            o_valid_q    <= o_valid_d;
            o_data_bus_q <= o_data_bus_d;
            o_cmd_q      <= o_cmd_d;
        end
    end

    assign o_valid    = o_valid_q;
    assign o_data_bus = o_data_bus_q;
    assign o_cmd      = o_cmd_q;

endmodule

// File: tb/tb_distribute_1x2_cmd_flow.sv
// tb_distribute_1x2_cmd_flow: scoreboard bench for a mid-tree node and a last-stage node
module tb_distribute_1x2_cmd_flow;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_en = 1'b0;
    logic [DW-1:0] i_data_bus = '0;
    logic [1:0]    i_cmd2 = '0;
    logic [0:0]    i_cmd1 = '0;

    logic [1:0]      o_valid2, o_valid1;
    logic [2*DW-1:0] o_data2, o_data1;
    logic [1:0]      o_cmd2;
    logic [0:0]      o_cmd1;

    typedef struct packed {
        logic [1:0]  v2;
        logic [63:0] d2;
        logic [1:0]  c2;
        logic [1:0]  v1;
        logic [63:0] d1;
        logic [0:0]  c1;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    distribute_1x2_cmd_flow #(.DATA_WIDTH(DW), .IN_COMMAND_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus), .i_en(i_en),
        .i_cmd(i_cmd2), .o_valid(o_valid2), .o_data_bus(o_data2), .o_cmd(o_cmd2)
    );

    distribute_1x2_cmd_flow #(.DATA_WIDTH(DW), .IN_COMMAND_WIDTH(1)) dut_last (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus), .i_en(i_en),
        .i_cmd(i_cmd1), .o_valid(o_valid1), .o_data_bus(o_data1), .o_cmd(o_cmd1)
    );

    // reference: tag picks a branch; data and remaining command shift into that branch's half
    function automatic exp_t model(input logic r, input logic v, input logic en,
                                   input logic [31:0] d, input logic [1:0] c2, input logic c1);
        exp_t e;
        e = '0;
        if (!r && v && en) begin
            e.v2 = c2[1] ? 2'd2 : 2'd1;
            e.d2 = 64'(d) << (c2[1] ? 32 : 0);
            e.c2 = 2'(c2[0]) << (c2[1] ? 1 : 0);
            e.v1 = c1 ? 2'd2 : 2'd1;
            e.d1 = 64'(d) << (c1 ? 32 : 0);
            e.c1 = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
        vectors++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic apply(input logic r, input logic v, input logic en,
                         input logic [31:0] d, input logic [1:0] c2, input logic c1);
        @(negedge clk);
        rst = r; i_valid = v; i_en = en; i_data_bus = d; i_cmd2 = c2; i_cmd1 = c1;
        if (r) begin
            #1;
            check("async_rst_valid", 64'(o_valid2), 64'd0);
            check("async_rst_data", o_data2, 64'd0);
            check("async_rst_cmd", 64'(o_cmd2), 64'd0);
            check("async_rst_last_valid", 64'(o_valid1), 64'd0);
            check("async_rst_last_data", o_data1, 64'd0);
        end
        q.push_back(model(r, v, en, d, c2, c1));
    endtask

    // monitor: each registered output cycle is matched against the oldest expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("valid", 64'(o_valid2), 64'(e.v2));
                check("data", o_data2, e.d2);
                check("cmd", 64'(o_cmd2), 64'(e.c2));
                check("last_valid", 64'(o_valid1), 64'(e.v1));
                check("last_data", o_data1, e.d1);
                check("last_cmd", 64'(o_cmd1), 64'(e.c1));
            end
        end
    end

    initial begin
        apply(1, 1, 1, 32'hAAAAAAAA, 2'b11, 1'b1);
        apply(1, 1, 1, 32'hAAAAAAAA, 2'b11, 1'b1);
        apply(0, 1, 1, 32'hAAAAAAAA, 2'b01, 1'b0);
        apply(0, 1, 1, 32'hAAAAAAAA, 2'b11, 1'b1);
        apply(0, 1, 0, 32'hAAAAAAAA, 2'b11, 1'b1);
        apply(0, 1, 1, 32'hAAAAAAAA, 2'b11, 1'b1);
        apply(0, 1, 1, 32'hBBBBBBBB, 2'b11, 1'b0);
        apply(0, 0, 1, 32'hBBBBBBBB, 2'b11, 1'b0);
        apply(0, 1, 1, 32'hCCCCCCCC, 2'b10, 1'b1);
        apply(1, 1, 1, 32'hDDDDDDDD, 2'b01, 1'b0);
        apply(0, 1, 1, 32'h12345678, 2'b00, 1'b1);
        for (int i = 0; i < 400; i++)
            apply(1'($urandom_range(49) == 0), 1'($urandom_range(3) != 0),
                  1'($urandom_range(4) != 0), $urandom, 2'($urandom), 1'($urandom));
        apply(0, 0, 0, '0, '0, '0);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #2;
        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/distribute_1x2_cmd_flow.md
Name: distribute_1x2_cmd_flow

Overview:
- 1-to-2 distribution switch node for the accelerator NoC distribution tree.
- Routes one input flit to the high or the low output branch, selected by the leading destination-tag bit of the command.
- Strips that tag and forwards the remaining command bits to the chosen branch, so a chain of these nodes self-routes.
- Outputs are registered: one cycle of latency.

Parameters:
- DATA_WIDTH, 32, width of one data flit.
- DESTINATION_TAG_WIDTH, 1, tag bits consumed per stage; only 1 is supported (elaboration error otherwise).
- IN_COMMAND_WIDTH, 2, width of the incoming command. Must be >= DESTINATION_TAG_WIDTH.
- OUT_COMMAND_WIDTH (local), derived:
  - 2*(IN_COMMAND_WIDTH-DESTINATION_TAG_WIDTH) if IN_COMMAND_WIDTH > DESTINATION_TAG_WIDTH;
  - otherwise DESTINATION_TAG_WIDTH (last stage).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  input flit valid.
- i_data_bus  in  DATA_WIDTH  input flit.
- i_en  in  1  node enable.
- i_cmd  in  IN_COMMAND_WIDTH  command; MSB is the routing tag, lower bits are the downstream command.
- o_valid  out  2  bit1 = high-branch valid, bit0 = low-branch valid.
- o_data_bus  out  2*DATA_WIDTH  [2*DATA_WIDTH-1:DATA_WIDTH] high branch, [DATA_WIDTH-1:0] low branch.
- o_cmd  out  OUT_COMMAND_WIDTH  downstream command; upper half goes to the high branch, lower half to the low branch.

Behaviour:
- Definitions:
  - tag = i_cmd[IN_COMMAND_WIDTH-1].
  - rest = i_cmd[IN_COMMAND_WIDTH-2:0] (multi-stage only).
  - fire = i_en & i_valid.
- Reset: while rst=1 (asynchronous), o_valid=2'b00, o_data_bus=0, o_cmd=0.
- All outputs update on the rising clk edge, latency 1 cycle. No backpressure; every fired flit is accepted.
- fire=1, tag=1:
  - o_valid=2'b10.
  - High data slice = i_data_bus; low slice = 0 (dummy).
  - o_cmd upper half = rest; lower half = 0.
- fire=1, tag=0:
  - o_valid=2'b01.
  - Low data slice = i_data_bus; high slice = 0.
  - o_cmd lower half = rest; upper half = 0.
- fire=0 (i_en=0 or i_valid=0): next cycle o_valid=2'b00, o_data_bus=0, o_cmd=0. Nothing is held over.
- Last stage (IN_COMMAND_WIDTH == DESTINATION_TAG_WIDTH): o_cmd is always 0; routing is identical.
- Multicast (both branches at once) is not supported. o_valid never equals 2'b11.
- Changing data or command while fire stays high: each cycle's outputs reflect the inputs sampled at the previous edge.
- Reset asserted mid-stream: outputs clear immediately. The first flit after reset release appears one cycle after the first edge at which fire=1.

Decomposition:
- Shared NoC package holds DESTINATION_TAG_WIDTH and the OUT_COMMAND_WIDTH derivation function, for reuse by the other tree nodes.
- One natural sub-module: distribute_1x2_route_comb. It does the combinational tag decode and the data/cmd steering.
- The top module adds the output register stage with asynchronous reset.

Test Plan:
1. Reset: rst=1 with i_valid=1, i_en=1, i_cmd=2'b11, data 32'hAAAAAAAA -> o_valid=0, o_data_bus=0, o_cmd=0, independent of clk.
2. Low route: i_en=1, i_valid=1, i_cmd=2'b01, data 32'hAAAAAAAA -> next edge: o_valid=2'b01, o_data_bus=64'h00000000_AAAAAAAA, o_cmd=2'b01.
3. High route: i_cmd=2'b11, data 32'hAAAAAAAA -> next edge: o_valid=2'b10, o_data_bus=64'hAAAAAAAA_00000000, o_cmd=2'b10.
4. Enable toggling: i_en=0 with i_valid=1, i_cmd=2'b11 -> o_valid=0, outputs zero. Re-enable -> high route resumes one cycle later.
5. Data change, then invalid input:
   - Data switches to 32'hBBBBBBBB with i_cmd=2'b11 -> high slice 32'hBBBBBBBB next cycle.
   - Then i_valid=0 -> o_valid=0 and data zero one cycle later.
6. Last stage: IN_COMMAND_WIDTH=1.
   - i_cmd=0 -> o_valid=2'b01, low slice carries data.
   - i_cmd=1 -> o_valid=2'b10.
   - o_cmd=0 throughout.
